mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers, placed in the EX stage of the five-stage MIPS pipeline.
- Consumes the forwarded rs/rt operand values read from the general register file.
- Runs MULT/MULTU/DIV/DIVU as multi-cycle operations and handles MTHI/MTLO in a single cycle.
- Exposes HI/LO for MFHI/MFLO, plus a busy/stall indication the hazard unit uses to freeze the F/D/E stages.

Parameters:
- MULT_CYCLES, 5, cycles busy is held after a MULT/MULTU is accepted (>=1).
- DIV_CYCLES, 10, cycles busy is held after a DIV/DIVU is accepted (>=1).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  EX-stage instruction is a valid MDU op this cycle
- op  input  3  MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 reserved, treated as NONE
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- cancel  input  1  exception/interrupt flush of the EX instruction this cycle
- busy  output  1  registered; multi-cycle operation in progress
- stall_req  output  1  combinational = busy | (start & ~cancel & op in {MULT..DIVU})
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (clk edge with reset=1): hi=0, lo=0, busy=0, internal counter=0, latched results cleared. Reset overrides all other inputs and aborts any in-flight operation.
- Accept condition: start=1, cancel=0, busy=0, op valid. A start with cancel=1 is ignored entirely, with no state change.
- MULT/MULTU, accepted at edge T0:
  - latch the 64-bit product (signed or unsigned) and load counter=MULT_CYCLES.
  - busy=1 from after T0 through edge T0+MULT_CYCLES.
  - at the edge where the counter goes 1->0: hi=product[63:32], lo=product[31:0], busy falls.
  - the new hi/lo are visible in the same cycle busy reads 0.
- DIV/DIVU: same sequencing with DIV_CYCLES; lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - rt_val=0: hi/lo unchanged at completion, but busy is still held for DIV_CYCLES.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO accepted at T0: hi (or lo) = rs_val at T0. Single cycle; busy never asserts.
- Operands are latched at acceptance; later changes to rs_val/rt_val have no effect on an in-flight op.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit guarantees stall_req holds the instruction in EX, so it is re-presented after busy falls.
- cancel while busy=1: has no effect on the in-flight op. The op was accepted by an older, committed instruction and completes normally.
- Counter width: clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- hi/lo are plain register outputs with no bypass. The hazard unit stalls MFHI/MFLO on stall_req.

Decomposition:
- Shared package mdu_pkg holds:
  - the op encoding constants (MDU_NONE..MDU_MTLO)
  - the op width localparam
  - the default cycle counts
- The decoder and hazard unit import the same package.
- No sub-module. Product, quotient and remainder are computed combinationally from the latched operands inside mdu_hilo; the sequencing is a single down-counter.

Test Plan:
- Reset, then MTHI rs=0x12345678 followed next cycle by MTLO rs=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, busy never 1.
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. With MULTU on the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> hi/lo unchanged, busy still 10 cycles.
- Start MULT and, during busy, present MTLO and a second MULT with different operands -> both ignored; the first result lands; stall_req=1 in every busy cycle.
- MULT with cancel=1 in the same cycle -> busy stays 0, hi/lo unchanged, stall_req=0.
- Reset asserted 3 cycles into a DIV -> busy=0, hi=lo=0 next cycle, and no late write-back occurs afterwards.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encoding and default sequencing lengths.
// Used by the decoder, the hazard unit and mdu_hilo.
package mdu_pkg;

    localparam int MDU_OP_W = 3;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd6;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // True for the ops that occupy the unit for more than one cycle.
    function automatic logic mdu_is_multicycle(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo.sv
// EX-stage multiply/divide unit with architectural HI/LO.
// Operands are latched on acceptance; the result is formed combinationally
// from the latched operands and written to HI/LO when a down-counter
// reaches zero, so the multi-cycle latency is purely a timing allowance.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         rs_val,
    input  logic [31:0]         rt_val,
    input  logic                cancel,
    output logic                busy,
    output logic                stall_req,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_signed;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_op_valid;
    logic        w_accept;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_ub_safe;
    logic [31:0] w_qmag;
    logic [31:0] w_rmag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_op_valid = (op >= MDU_MULT) && (op <= MDU_MTLO);
    assign w_accept   = start & ~cancel & ~busy & w_op_valid;

    assign busy      = (r_cnt != '0);
    assign stall_req = busy | (start & ~cancel & mdu_is_multicycle(op));
    assign hi        = r_hi;
    assign lo        = r_lo;

    // 64x64 with sign/zero extension gives the correct low 64 bits for
    // both MULT and MULTU.
    assign w_a64  = r_signed ? {{32{r_a[31]}}, r_a} : {32'b0, r_a};
    assign w_b64  = r_signed ? {{32{r_b[31]}}, r_b} : {32'b0, r_b};
    assign w_prod = w_a64 * w_b64;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. 0x80000000 / -1 falls out as
    // 0x80000000 rem 0 without special casing. Divisor 0 is masked to 1
    // here and the write-back is suppressed instead.
    assign w_a_neg   = r_signed & r_a[31];
    assign w_b_neg   = r_signed & r_b[31];
    assign w_ua      = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_ub      = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_ub_safe = (w_ub == 32'd0) ? 32'd1 : w_ub;
    assign w_qmag    = w_ua / w_ub_safe;
    assign w_rmag    = w_ua % w_ub_safe;
    assign w_quo     = (w_a_neg ^ w_b_neg) ? (~w_qmag + 32'd1) : w_qmag;
    assign w_rem     = w_a_neg ? (~w_rmag + 32'd1) : w_rmag;

    // Accept new ops when idle, count down in-flight ops, write back at 1->0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            case (op)
                MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                    r_is_div <= (op == MDU_DIV) || (op == MDU_DIVU);
                    r_signed <= (op == MDU_MULT) || (op == MDU_DIV);
                    r_a      <= rs_val;
                    r_b      <= rt_val;
                    r_cnt    <= ((op == MDU_DIV) || (op == MDU_DIVU)) ?
                                CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
                MDU_MTHI: r_hi <= rs_val;
                MDU_MTLO: r_lo <= rs_val;
                default: ;
            endcase
        end else if (busy) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                if (!r_is_div) begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end else if (r_b != 32'd0) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vector table, hand-written
// multi-cycle corner sequences, then random ops against a longint model.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t tbl[9];

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: architectural effect of one op, with plain 64-bit arithmetic.
    task automatic model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
        longint sa, sb, q, r;
        longint unsigned up;
        cyc = 0;
        case (mop)
            MDU_MULT: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = sa * sb;
                m_hi = q[63:32]; m_lo = q[31:0]; cyc = 5;
            end
            MDU_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                m_hi = up[63:32]; m_lo = up[31:0]; cyc = 5;
            end
            MDU_DIV, MDU_DIVU: begin
                if (mop == MDU_DIV) begin
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                end else begin
                    sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
                end
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
                cyc = 10;
            end
            MDU_MTHI: m_hi = a;
            MDU_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Present one op for a single cycle, then count busy cycles (bounded).
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc);
        int n;
        start = 1'b1; op = o; rs_val = a; rt_val = b; cancel = 1'b0;
        #1;
        chk({name, " stall_req"}, {31'b0, stall_req}, {31'b0, mdu_is_multicycle(o)});
        tick();
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk({name, " busy_cycles"}, n, ecyc);
        chk({name, " hi"}, hi, ehi);
        chk({name, " lo"}, lo, elo);
    endtask

    initial begin
        int n;
        int cyc;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tbl[0] = '{MDU_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        tbl[1] = '{MDU_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
        tbl[2] = '{MDU_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        tbl[3] = '{MDU_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
        tbl[4] = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[5] = '{MDU_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[6] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        tbl[7] = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        tbl[8] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};

        reset = 1'b1; start = 1'b0; op = MDU_NONE; rs_val = 0; rt_val = 0; cancel = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt,
                   tbl[i].hi, tbl[i].lo, tbl[i].cyc);
        end

        // MULT in flight; MTLO and a second MULT presented during busy are ignored
        start = 1'b1; op = MDU_MULT; rs_val = 32'hFFFFFFFE; rt_val = 32'h3;
        tick();
        n = 0;
        while (busy && n < 100) begin
            chk("ovl stall_req", {31'b0, stall_req}, 32'h1);
            op = (n % 2 == 0) ? MDU_MTLO : MDU_MULT;
            rs_val = 32'hDEAD0000 + n; rt_val = 32'h9;
            n++;
            tick();
            if (!busy) start = 1'b0;
        end
        start = 1'b0;
        chk("ovl busy_cycles", n, 5);
        chk("ovl hi", hi, 32'hFFFFFFFF);
        chk("ovl lo", lo, 32'hFFFFFFFA);
        tick();
        chk("ovl no_reaccept", {31'b0, busy}, 32'h0);

        // MULT with cancel in the same cycle is dropped
        start = 1'b1; cancel = 1'b1; op = MDU_MULT; rs_val = 32'h7; rt_val = 32'h9;
        #1;
        chk("cancel stall_req", {31'b0, stall_req}, 32'h0);
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("cancel busy", {31'b0, busy}, 32'h0);
        chk("cancel hi", hi, 32'hFFFFFFFF);
        chk("cancel lo", lo, 32'hFFFFFFFA);

        // cancel during busy does not abort the in-flight op
        start = 1'b1; op = MDU_MULTU; rs_val = 32'h10; rt_val = 32'h20;
        tick();
        start = 1'b0; cancel = 1'b1;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        cancel = 1'b0;
        chk("busycancel cycles", n, 5);
        chk("busycancel lo", lo, 32'h200);
        chk("busycancel hi", hi, 32'h0);

        // Reset three cycles into a DIV: everything cleared, no late write-back
        start = 1'b1; op = MDU_DIV; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstdiv busy", {31'b0, busy}, 32'h0);
        chk("rstdiv hi", hi, 32'h0);
        chk("rstdiv lo", lo, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        chk("rstdiv late hi", hi, 32'h0);
        chk("rstdiv late lo", lo, 32'h0);
        chk("rstdiv late busy", {31'b0, busy}, 32'h0);

        // Random ops against the model
        m_hi = 32'h0; m_lo = 32'h0;
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(1, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            model(rop, ra, rb, cyc);
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, m_hi, m_lo, cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
